// File: rtl/accumulator_bank_pkg.sv
// Shared accelerator definitions: drain FSM states, saturation limits and the
// row-to-entry mapping used by both the crossbar and the accumulator bank.
package accumulator_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } acc_state_e;

   // Largest signed value representable in 'width' bits (0x7F for 8 bits).
   function automatic logic [63:0] sat_max_of(input int unsigned width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   // Bit pattern of the most negative value in 'width' bits (0x80 for 8 bits).
   function automatic logic [63:0] sat_min_of(input int unsigned width);
      return 64'd1 << (width - 1);
   endfunction

   // Entry addressed by a crossbar row in the given operating mode.
   function automatic int unsigned entry_from_row(input int unsigned row, input logic [1:0] bw);
      return row >> bw;
   endfunction

endpackage

// File: rtl/accumulator_bank_ram.sv
// Accumulator storage: one registered read port, one write port, and every
// entry cleared by the asynchronous reset. Read-during-write to the same
// address returns the old contents; the caller forwards around that.
module accumulator_bank_ram #(
   parameter int DEPTH      = 256,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [DATA_WIDTH-1:0] mem_rd [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_entry
         logic [DATA_WIDTH-1:0] entry_q;
         logic [DATA_WIDTH-1:0] entry_d;

         // Load the entry only when the write port targets it.
         always_comb begin
            entry_d = entry_q;
            if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
               entry_d = wr_data;
            end
         end

         // Entry register, zeroed by reset.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               entry_q <= '0;
            end else begin
               entry_q <= entry_d;
            end
         end

         assign mem_rd[gi] = entry_q;
      end
   endgenerate

   // Read data register updates only on a read, so it holds between reads.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_rd[rd_addr];
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/accumulator_bank.sv
// Accumulator bank: saturating read-modify-write accumulation of crossbar
// products into per-entry storage, plus a flush/drain sequencer that streams
// the tile out with valid/ready and clears each entry as it is consumed.
module accumulator_bank
   import accumulator_bank_pkg::*;
#(
   parameter int TILE_SIZE   = 256,
   parameter int DATA_WIDTH  = 8,
   parameter int ENTRY_WIDTH = $clog2(TILE_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [1:0]             bitwidth,
   input  logic [ENTRY_WIDTH-1:0] buffer_row_write,
   input  logic [DATA_WIDTH-1:0]  buffer_data_write,
   input  logic                   buffer_write_enable,
   input  logic                   drain_start,
   output logic                   drain_valid,
   input  logic                   drain_ready,
   output logic [ENTRY_WIDTH-1:0] drain_entry,
   output logic [DATA_WIDTH-1:0]  drain_data,
   output logic                   drain_last,
   output logic                   busy,
   output logic                   sat_error,
   output logic                   drop_error,
   input  logic                   clear_errors
);

   localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max_of(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min_of(DATA_WIDTH));

   // Sequencer state
   acc_state_e             state_q, state_d;
   logic [1:0]             bw_q, bw_d;
   logic                   flush_cnt_q, flush_cnt_d;
   logic [ENTRY_WIDTH-1:0] drain_idx_q, drain_idx_d;
   logic                   drain_valid_q, drain_valid_d;

   // Stage 1 of the accumulate pipeline
   logic                   s1_valid_q, s1_valid_d;
   logic [ENTRY_WIDTH-1:0] s1_entry_q, s1_entry_d;
   logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;

   // Forwarded write-back value captured alongside each storage read
   logic                   fwd_hit_q, fwd_hit_d;
   logic [DATA_WIDTH-1:0]  fwd_val_q, fwd_val_d;

   // Sticky error flags
   logic                   sat_error_q, sat_error_d;
   logic                   drop_error_q, drop_error_d;

   // Combinational helpers
   logic [31:0]            row_entry;
   logic [31:0]            entry_limit;
   logic                   write_open;
   logic                   wr_accept;
   logic                   wr_drop;
   logic [DATA_WIDTH-1:0]  old_val;
   logic [DATA_WIDTH:0]    sum_ext;
   logic                   sum_ovf;
   logic [DATA_WIDTH-1:0]  wb_val;
   logic                   sat_event;
   logic [31:0]            drain_count;
   logic                   drain_is_last;
   logic                   drain_fetch;
   logic [ENTRY_WIDTH-1:0] fetch_addr;
   logic                   beat_clear;

   // Storage ports
   logic                   ram_rd_en;
   logic [ENTRY_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0]  ram_rd_data;
   logic                   ram_wr_en;
   logic [ENTRY_WIDTH-1:0] ram_wr_addr;
   logic [DATA_WIDTH-1:0]  ram_wr_data;

   accumulator_bank_ram #(
      .DEPTH      (TILE_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ENTRY_WIDTH)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data)
   );

   // Map the incoming row to an entry and decide whether the write is taken.
   always_comb begin
      row_entry   = entry_from_row(32'(buffer_row_write), bitwidth);
      entry_limit = 32'(TILE_SIZE) >> bitwidth;
      write_open  = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
      wr_accept   = buffer_write_enable && write_open && (row_entry < entry_limit);
      wr_drop     = buffer_write_enable && !wr_accept;
   end

   // Stage 2: signed add of the stored (or forwarded) value, clamped to range.
   always_comb begin
      old_val = fwd_hit_q ? fwd_val_q : ram_rd_data;
      sum_ext = {old_val[DATA_WIDTH-1], old_val} + {s1_data_q[DATA_WIDTH-1], s1_data_q};
      sum_ovf = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
      if (!sum_ovf) begin
         wb_val = sum_ext[DATA_WIDTH-1:0];
      end else if (sum_ext[DATA_WIDTH]) begin
         wb_val = SAT_MIN;
      end else begin
         wb_val = SAT_MAX;
      end
      sat_event = s1_valid_q && sum_ovf;
   end

   // Last entry of the current drain, from the mode latched at drain_start.
   always_comb begin
      drain_count   = 32'(TILE_SIZE) >> bw_q;
      drain_is_last = (32'(drain_idx_q) == (drain_count - 32'd1));
   end

   // Sequencer next state: flush the pipeline, then fetch/present/clear entries.
   always_comb begin
      state_d       = state_q;
      bw_d          = bw_q;
      flush_cnt_d   = flush_cnt_q;
      drain_idx_d   = drain_idx_q;
      drain_valid_d = drain_valid_q;
      drain_fetch   = 1'b0;
      fetch_addr    = drain_idx_q;
      beat_clear    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drain_start) begin
               state_d     = ST_FLUSH;
               bw_d        = bitwidth;
               flush_cnt_d = 1'b0;
               drain_idx_d = '0;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q) begin
               state_d = ST_DRAIN;
            end else begin
               flush_cnt_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!drain_valid_q) begin
               // First cycle in DRAIN: the final flush write may still be in
               // stage 1, so the fetch of entry 0 goes through the forward path.
               drain_fetch   = 1'b1;
               drain_valid_d = 1'b1;
            end else if (drain_ready) begin
               beat_clear = 1'b1;
               if (drain_is_last) begin
                  drain_valid_d = 1'b0;
                  state_d       = ST_DONE;
               end else begin
                  drain_idx_d = drain_idx_q + ENTRY_WIDTH'(1);
                  drain_fetch = 1'b1;
                  fetch_addr  = drain_idx_q + ENTRY_WIDTH'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Storage port steering, stage 1 load and forward capture.
   always_comb begin
      ram_rd_en   = wr_accept || drain_fetch;
      ram_rd_addr = drain_fetch ? fetch_addr : ENTRY_WIDTH'(row_entry);
      ram_wr_en   = s1_valid_q || beat_clear;
      ram_wr_addr = s1_valid_q ? s1_entry_q : drain_idx_q;
      ram_wr_data = s1_valid_q ? wb_val : '0;

      s1_valid_d  = wr_accept;
      s1_entry_d  = ENTRY_WIDTH'(row_entry);
      s1_data_d   = buffer_data_write;

      // A read racing the stage-2 write of the same entry takes the new value.
      fwd_hit_d   = fwd_hit_q;
      fwd_val_d   = fwd_val_q;
      if (ram_rd_en) begin
         fwd_hit_d = s1_valid_q && (s1_entry_q == ram_rd_addr);
         fwd_val_d = wb_val;
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear.
   always_comb begin
      sat_error_d  = clear_errors ? 1'b0 : sat_error_q;
      drop_error_d = clear_errors ? 1'b0 : drop_error_q;
      if (sat_event) begin
         sat_error_d = 1'b1;
      end
      if (wr_drop) begin
         drop_error_d = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         bw_q          <= '0;
         flush_cnt_q   <= 1'b0;
         drain_idx_q   <= '0;
         drain_valid_q <= 1'b0;
         s1_valid_q    <= 1'b0;
         s1_entry_q    <= '0;
         s1_data_q     <= '0;
         fwd_hit_q     <= 1'b0;
         fwd_val_q     <= '0;
         sat_error_q   <= 1'b0;
         drop_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         bw_q          <= bw_d;
         flush_cnt_q   <= flush_cnt_d;
         drain_idx_q   <= drain_idx_d;
         drain_valid_q <= drain_valid_d;
         s1_valid_q    <= s1_valid_d;
         s1_entry_q    <= s1_entry_d;
         s1_data_q     <= s1_data_d;
         fwd_hit_q     <= fwd_hit_d;
         fwd_val_q     <= fwd_val_d;
         sat_error_q   <= sat_error_d;
         drop_error_q  <= drop_error_d;
      end
   end

   assign drain_valid = drain_valid_q;
   assign drain_entry = drain_idx_q;
   assign drain_data  = old_val;
   assign drain_last  = drain_valid_q && drain_is_last;
   assign busy        = (state_q != ST_IDLE);
   assign sat_error   = sat_error_q;
   assign drop_error  = drop_error_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank: directed scenarios plus random
// writes and random backpressure, checked against an arithmetic model.
module tb_accumulator_bank;

   localparam int TILE = 256;
   localparam int DW   = 8;
   localparam int EW   = 8;

   logic          clk                 = 1'b0;
   logic          reset_n             = 1'b0;
   logic [1:0]    bitwidth            = 2'd0;
   logic [EW-1:0] buffer_row_write    = '0;
   logic [DW-1:0] buffer_data_write   = '0;
   logic          buffer_write_enable = 1'b0;
   logic          drain_start         = 1'b0;
   logic          drain_ready         = 1'b0;
   logic          clear_errors        = 1'b0;
   logic          drain_valid;
   logic          drain_last;
   logic          busy;
   logic          sat_error;
   logic          drop_error;
   logic [EW-1:0] drain_entry;
   logic [DW-1:0] drain_data;

   int n_checks = 0;
   int n_fail   = 0;
   int model_mem [TILE];
   int model_sat  = 0;
   int model_drop = 0;

   accumulator_bank #(
      .TILE_SIZE   (TILE),
      .DATA_WIDTH  (DW),
      .ENTRY_WIDTH (EW)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .bitwidth            (bitwidth),
      .buffer_row_write    (buffer_row_write),
      .buffer_data_write   (buffer_data_write),
      .buffer_write_enable (buffer_write_enable),
      .drain_start         (drain_start),
      .drain_valid         (drain_valid),
      .drain_ready         (drain_ready),
      .drain_entry         (drain_entry),
      .drain_data          (drain_data),
      .drain_last          (drain_last),
      .busy                (busy),
      .sat_error           (sat_error),
      .drop_error          (drop_error),
      .clear_errors        (clear_errors)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accumulate into the model with clamping at the signed 8-bit limits.
   task automatic model_apply(input int row, input logic [DW-1:0] data);
      int e;
      int s;
      e = row >> bitwidth;
      s = model_mem[e] + int'($signed(data));
      if (s > 127) begin
         s = 127;
         model_sat = 1;
      end else if (s < -128) begin
         s = -128;
         model_sat = 1;
      end
      model_mem[e] = s;
   endtask

   task automatic do_write(input int row, input int data);
      buffer_write_enable = 1'b1;
      buffer_row_write    = EW'(row);
      buffer_data_write   = DW'(data);
      model_apply(row, DW'(data));
      step();
      buffer_write_enable = 1'b0;
   endtask

   task automatic rand_writes(input int bw, input int n);
      int row;
      bitwidth = 2'(bw);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            row = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, TILE - 1));
            buffer_write_enable = 1'b1;
            buffer_row_write    = EW'(row);
            buffer_data_write   = DW'($urandom);
            model_apply(row, buffer_data_write);
         end else begin
            buffer_write_enable = 1'b0;
         end
         step();
      end
      buffer_write_enable = 1'b0;
      step();
      step();
   endtask

   task automatic pulse_clear();
      clear_errors = 1'b1;
      step();
      clear_errors = 1'b0;
      model_sat  = 0;
      model_drop = 0;
      check("sat_cleared", 32'(sat_error), model_sat);
      check("drop_cleared", 32'(drop_error), model_drop);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_sat"}, 32'(sat_error), model_sat);
      check({tag, "_drop"}, 32'(drop_error), model_drop);
   endtask

   // ready_mode: 0 always ready, 1 toggling, 2 random. abort_beat < 0 runs to completion.
   task automatic run_drain(input int bw, input int ready_mode, input bit flush_wr,
                            input bit mid_wr, input int abort_beat);
      int  count;
      int  beats    = 0;
      int  cyc      = 0;
      int  waited   = 0;
      bit  finished = 0;
      bit  aborted  = 0;
      bit  injected = 0;
      bit  tog      = 0;
      int  row;
      count       = TILE >> bw;
      bitwidth    = 2'(bw);
      drain_start = 1'b1;
      // Cycle of drain_start and both FLUSH cycles; writes here must land.
      for (int k = 0; k < 3; k++) begin
         if (flush_wr) begin
            row = int'($urandom_range(0, (1 << bw) - 1));
            buffer_write_enable = 1'b1;
            buffer_row_write    = EW'(row);
            buffer_data_write   = DW'($urandom_range(1, 20));
            model_apply(row, buffer_data_write);
         end
         step();
         drain_start = 1'b0;
         buffer_write_enable = 1'b0;
      end
      check("busy_in_drain", 32'(busy), 1);
      while (!finished && !aborted && cyc < 4 * count + 50) begin
         if (abort_beat >= 0 && beats == abort_beat && drain_valid) begin
            reset_n = 1'b0;
            #1;
            check("rst_valid", 32'(drain_valid), 0);
            check("rst_last", 32'(drain_last), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_entry", 32'(drain_entry), 0);
            check("rst_data", 32'(drain_data), 0);
            check("rst_sat", 32'(sat_error), 0);
            check("rst_drop", 32'(drop_error), 0);
            for (int e = 0; e < TILE; e++) model_mem[e] = 0;
            model_sat   = 0;
            model_drop  = 0;
            drain_ready = 1'b0;
            step();
            step();
            reset_n = 1'b1;
            for (int k = 0; k < 20; k++) begin
               step();
               check("post_rst_valid", 32'(drain_valid), 0);
            end
            check("post_rst_busy", 32'(busy), 0);
            aborted = 1;
         end else begin
            case (ready_mode)
               0:       drain_ready = 1'b1;
               1:       drain_ready = tog;
               default: drain_ready = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            if (mid_wr && !injected && beats == 5 && drain_valid) begin
               // Write in DRAIN is dropped; the clear and restart in the same
               // cycle must not hide the drop nor start a second drain.
               buffer_write_enable = 1'b1;
               buffer_row_write    = EW'($urandom_range(0, TILE - 1));
               buffer_data_write   = DW'($urandom_range(1, 50));
               clear_errors        = 1'b1;
               drain_start         = 1'b1;
               model_sat           = 0;
               model_drop          = 1;
               injected            = 1;
            end
            if (drain_valid) begin
               check("drain_entry", 32'(drain_entry), beats);
               check("drain_data", 32'($signed(drain_data)), model_mem[beats]);
               check("drain_last", 32'(drain_last), (beats == count - 1) ? 1 : 0);
               if (drain_ready) begin
                  model_mem[beats] = 0;
                  beats++;
                  if (beats == count) finished = 1;
               end
            end else begin
               check("last_idle", 32'(drain_last), 0);
            end
            step();
            cyc++;
            buffer_write_enable = 1'b0;
            clear_errors        = 1'b0;
            drain_start         = 1'b0;
         end
      end
      drain_ready = 1'b0;
      if (!aborted) begin
         if (!finished) check("drain_beats", beats, count);
         while (busy && waited < 10) begin
            step();
            waited++;
         end
         check("busy_release", 32'(busy), 0);
         for (int k = 0; k < 5; k++) begin
            step();
            check("stay_idle", 32'(busy), 0);
            check("stay_invalid", 32'(drain_valid), 0);
         end
      end
   endtask

   initial begin
      for (int e = 0; e < TILE; e++) model_mem[e] = 0;
      repeat (3) step();
      check("reset_valid", 32'(drain_valid), 0);
      check("reset_last", 32'(drain_last), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_sat", 32'(sat_error), 0);
      check("reset_drop", 32'(drop_error), 0);
      check("reset_entry", 32'(drain_entry), 0);
      check("reset_data", 32'(drain_data), 0);
      reset_n = 1'b1;
      step();

      // Single write, forwarding chain and both saturation directions.
      bitwidth = 2'd2;
      do_write(8, 5);
      step();
      step();
      do_write(4, 3);
      do_write(4, 4);
      do_write(4, -2);
      do_write(12, 100);
      do_write(12, 100);
      do_write(16, -128);
      do_write(16, -1);
      step();
      step();
      check_flags("directed");
      run_drain(2, 0, 0, 0, -1);
      pulse_clear();

      // Backpressure with ready toggling, then confirm the tile reads back zero.
      rand_writes(2, 60);
      run_drain(2, 1, 0, 0, -1);
      check_flags("toggle");
      run_drain(2, 0, 0, 0, -1);
      pulse_clear();

      // Write during DRAIN with a coinciding clear and an ignored drain_start.
      rand_writes(2, 30);
      run_drain(2, 2, 0, 1, -1);
      check_flags("mid_write");
      pulse_clear();

      // Every mode, random data, random backpressure, writes during FLUSH.
      for (int bw = 0; bw < 4; bw++) begin
         rand_writes(bw, 80);
         run_drain(bw, 2, 1, 0, -1);
         check_flags("random");
      end

      // Reset at beat 10, then a full drain that must read all zeros.
      rand_writes(2, 40);
      run_drain(2, 2, 0, 0, 10);
      run_drain(0, 0, 0, 0, -1);
      check_flags("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
